gcd_arbiter: RTL

- Shares one gcd core among NREQ independent requesters using round-robin arbitration.
- Sequences each accepted job: grant, issue to the core, wait for the result, then park the result in a per-requester response register.
- Guards the core against operand a == 0, which never terminates on the core, by completing such jobs locally.
- Sits between requester logic and a single gcd instance; it owns the core's a, b and in_valid inputs.

---
 rtl/gcd_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one gcd core among NREQ requesters, one job in flight.
// Accept -> core_in_valid next cycle; results are parked per requester until resp_ready; a == 0 completes locally.
module gcd_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       resp_valid,
  output logic [NREQ*WIDTH-1:0] resp_o,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]      core_a,
  output logic [WIDTH-1:0]      core_b,
  output logic                  core_in_valid,
  input  logic                  core_in_ready,
  input  logic                  core_out_valid,
  input  logic [WIDTH-1:0]      core_o,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   rr_next;
  logic [NREQ-1:0]  resp_valid_q;
  logic [NREQ-1:0]  resp_set;
  logic [NREQ-1:0]  resp_clr;
  logic [WIDTH-1:0] resp_q [NREQ];
  logic [WIDTH-1:0] a_arr  [NREQ];
  logic [WIDTH-1:0] b_arr  [NREQ];

  logic [NREQ-1:0]  eligible;
  logic             pick_vld;
  logic [IDW-1:0]   pick_id;
  logic [IDW:0]     scan_sum;

  logic             accept;
  logic             complete;
  logic [WIDTH-1:0] complete_dat;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    assign resp_o[i*WIDTH +: WIDTH] = resp_q[i];
  end

  // Registered resp_valid gates eligibility, so a consumed requester returns one cycle later.
  assign eligible   = req_valid & ~resp_valid_q;
  assign resp_valid = resp_valid_q;
  assign busy       = (state != IDLE);

  // Scan downward so the candidate closest to rr_ptr is the last one written and wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    scan_sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NREQ)) begin
        scan_sum = scan_sum - (IDW+1)'(NREQ);
      end
      if (eligible[scan_sum[IDW-1:0]]) begin
        pick_vld = 1'b1;
        pick_id  = scan_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    complete      = 1'b0;
    complete_dat  = core_o;
    core_in_valid = 1'b0;
    req_ready     = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          req_ready[pick_id] = 1'b1;
          accept             = 1'b1;
          state_nxt          = ISSUE;
        end
      end
      ISSUE: begin
        // a == 0 would never terminate on the core; gcd(0, b) = b.
        if (core_a == '0) begin
          complete     = 1'b1;
          complete_dat = core_b;
          state_nxt    = IDLE;
        end else begin
          core_in_valid = 1'b1;
          if (core_in_ready) begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (core_out_valid) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

  always_comb begin
    resp_set = '0;
    if (complete) begin
      resp_set[grant_id] = 1'b1;
    end
  end

  assign resp_clr = resp_valid_q & resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      grant_id <= '0;
      core_a   <= '0;
      core_b   <= '0;
    end else begin
      if (accept) begin
        grant_id <= pick_id;
        core_a   <= a_arr[pick_id];
        core_b   <= b_arr[pick_id];
      end
      if (complete) begin
        rr_ptr <= rr_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        resp_q[i] <= '0;
      end
    end else begin
      resp_valid_q <= resp_set | (resp_valid_q & ~resp_clr);
      if (complete) begin
        resp_q[grant_id] <= complete_dat;
      end
    end
  end

  a_req_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_no_overwrite:     assert property (@(posedge clk) disable iff (rst) !(complete && resp_valid_q[grant_id]));

endmodule
